vec_sequencer: RTL



---
 rtl/dld_seq_pkg.sv | 13 +
 rtl/dwell_timer.sv | 34 +++
 rtl/vec_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dld_seq_pkg.sv
// Shared types and widths for the 4-input test-vector sequencer.
package dld_seq_pkg;

   localparam int CODE_W  = 4;
   localparam int TRUTH_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      DONE
   } seq_state_e;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts enabled cycles up to DWELL-1, then wraps.
module dwell_timer #(
   parameter int DWELL = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(DWELL + 1);
   localparam logic [CW-1:0] TC_VAL = CW'(DWELL - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc = (cnt_q == TC_VAL);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = tc ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/vec_sequencer.sv
// Walks codes 0..LAST onto {A,B,C,D}, each held DWELL un-held cycles.
// Define SEQ_CAPTURE_EN to record F per code into truth.
module vec_sequencer
   import dld_seq_pkg::*;
#(
   parameter int DWELL = 20,
   parameter int LAST  = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               hold,
   output logic               A,
   output logic               B,
   output logic               C,
   output logic               D,
   output logic [CODE_W-1:0]  idx,
   output logic               busy,
   output logic               done,
   input  logic               F,
   output logic [TRUTH_W-1:0] truth
);

   localparam logic [CODE_W-1:0] LAST_C = CODE_W'(LAST);

   seq_state_e        state_q, state_d;
   logic [CODE_W-1:0] idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic go, tmr_en, tc, adv;

   // start only launches a run when not already driving
   assign go     = start && (state_q != DRIVE);
   assign tmr_en = (state_q == DRIVE) && !hold;
   assign adv    = tmr_en && tc;

   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (go),
      .en    (tmr_en),
      .tc    (tc)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = done_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = DRIVE;
               idx_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         DRIVE: begin
            if (adv) begin
               if (idx_q == LAST_C) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + CODE_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign idx  = idx_q;
   assign A    = idx_q[3];
   assign B    = idx_q[2];
   assign C    = idx_q[1];
   assign D    = idx_q[0];
   assign busy = busy_q;
   assign done = done_q;

`ifdef SEQ_CAPTURE_EN
   logic [TRUTH_W-1:0] truth_q, truth_d;

   // F is taken on the last dwell cycle of each code
   always_comb begin
      truth_d = truth_q;
      if (go)
         truth_d = '0;
      else if (adv)
         truth_d[idx_q] = F;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         truth_q <= '0;
      else
         truth_q <= truth_d;
   end

   assign truth = truth_q;
`else
   logic unused_f;
   assign unused_f = F;
   assign truth    = '0;
`endif

endmodule
